// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: debounce FSM encodings and the
// default debounce window.
package button_conditioner_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 10000;

    localparam logic [1:0] StStableLow  = 2'd0;
    localparam logic [1:0] StWaitHigh   = 2'd1;
    localparam logic [1:0] StStableHigh = 2'd2;
    localparam logic [1:0] StWaitLow    = 2'd3;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with saturating-free
// counter, and registered level / press / release outputs.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic res,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sync;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    assign sync = sync_q[1];

    // Counter defaults to 0 so stable states hold it cleared and every entry
    // into a wait state starts from 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            StStableLow: begin
                if (sync) state_d = StWaitHigh;
            end
            StWaitHigh: begin
                if (!sync) begin
                    state_d = StStableLow;
                end else if (cnt_q == CntMax) begin
                    state_d = StStableHigh;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStableHigh: begin
                if (!sync) state_d = StWaitLow;
            end
            StWaitLow: begin
                if (sync) begin
                    state_d = StStableHigh;
                end else if (cnt_q == CntMax) begin
                    state_d   = StStableLow;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StStableLow;
        endcase
        level_d = (state_d == StStableHigh) || (state_d == StWaitLow);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync_q    <= 2'b00;
            state_q   <= StStableLow;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_in};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a bus of raw button pins into clean levels and one-cycle
// press/release pulses; one independent debounce_channel per pin.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned CHANNELS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                res,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release
);

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : gen_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .res        (res),
            .btn_in     (btn_in[g]),
            .btn_level  (btn_level[g]),
            .btn_press  (btn_press[g]),
            .btn_release(btn_release[g])
        );
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter CHANNELS, default 3, number of independent button channels (bit 0 start/stop, bit 1 lap, bit 2 user reset).
REQ-002 Parameter DEBOUNCE_CYCLES, default 10000, stable-clock-cycle count required to accept a level change (10 ms at 1 MHz); legal range 2..16383.
REQ-003 clk  input  1  system clock, 1 MHz; all flops clock on the rising edge.
REQ-004 res  input  1  reset; asynchronous, active-low.
REQ-005 btn_in  input  CHANNELS  raw asynchronous button pins, active-high, idle low.
REQ-006 btn_level  output  CHANNELS  debounced button level, registered.
REQ-007 btn_press  output  CHANNELS  one-cycle pulse on each accepted 0->1 transition, registered.
REQ-008 btn_release  output  CHANNELS  one-cycle pulse on each accepted 1->0 transition, registered.

Function
REQ-009 Each channel shall pass btn_in through a 2-flop synchronizer; only the second flop output (sync) feeds the logic.
REQ-010 Each channel shall run an FSM with four states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-011 STABLE_LOW with sync=1 -> WAIT_HIGH with counter cleared to 0; STABLE_HIGH with sync=0 -> WAIT_LOW with counter cleared to 0.
REQ-012 WAIT_HIGH: sync=0 -> STABLE_LOW, no pulse; sync=1 and counter<DEBOUNCE_CYCLES-1 -> counter+1; sync=1 and counter=DEBOUNCE_CYCLES-1 -> STABLE_HIGH.
REQ-013 WAIT_LOW mirrors REQ-012 with polarity inverted, exiting to STABLE_LOW on accept and to STABLE_HIGH on abort.
REQ-014 btn_level shall be 1 exactly in STABLE_HIGH and WAIT_LOW; it changes on the same edge as the accepting state transition.
REQ-015 btn_press (btn_release) shall be high for exactly the one cycle following the edge that enters STABLE_HIGH (STABLE_LOW) from WAIT_HIGH (WAIT_LOW); it is never asserted on an abort.
REQ-016 Latency: with edge 1 being the first rising edge sampling a new stable btn_in value, btn_level and the pulse shall update on edge DEBOUNCE_CYCLES+3.
REQ-017 Any input pulse or gap whose synchronized width is at most DEBOUNCE_CYCLES cycles shall be rejected with no output change.
REQ-018 The counter shall be ceil(log2(DEBOUNCE_CYCLES)) bits wide, shall never wrap, and shall hold 0 in stable states.
REQ-019 Channels shall be fully independent; simultaneous pulses on several channels in one cycle are legal.
REQ-020 btn_press and btn_release of one channel shall never be high in the same cycle; two pulses of one channel shall be at least DEBOUNCE_CYCLES+1 cycles apart.

Reset
REQ-021 While res=0, regardless of clk: synchronizer flops 0, state STABLE_LOW, counter 0, btn_level/btn_press/btn_release all 0.
REQ-022 Reset asserted mid-debounce shall discard the pending transition with no pulse, including a pulse that would have fired on the same edge.
REQ-023 Once res deasserts, a button held high shall be treated as a new press and produce btn_press after the full REQ-016 latency.

Structure
REQ-024 A shared package shall hold the FSM state encodings (2 bits) and the default DEBOUNCE_CYCLES constant.
REQ-025 Per-channel logic shall live in one sub-module, debounce_channel, instantiated CHANNELS times by generate; button_conditioner contains only instantiation and bus wiring.
REQ-026 Outputs shall drive the stopwatch controller, which is then clocked by clk and enabled by btn_press instead of by raw pin edges.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 btn_in[0] rises and is held high: btn_level[0]=1 and btn_press[0]=1 from edge 7, btn_press[0]=0 from edge 8; other channels stay 0.
REQ-028 btn_in[1] high for 3 cycles, then low: btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
REQ-029 Bounce on btn_in[0] (1,0,1,1,0,1, then held high): exactly one btn_press[0] pulse, 7 edges after the final rise; on release, exactly one btn_release[0] pulse.
REQ-030 btn_in[0] and btn_in[2] rise on the same edge: btn_press[0] and btn_press[2] pulse in the same cycle.
REQ-031 res pulsed low at edge 5 of a press, button still held: no pulse before reset; all outputs read 0 during reset; btn_press fires 7 edges after res deasserts.
